nn_class_decider: RTL and testbench
===================================

# nn_class_decider

Post-processing stage fed directly by the output layer. It accepts the three signed 9-bit class scores through a valid/ready handshake and finds the winning class with a sequential scan. It applies an optional confidence-margin check, then debounces successive decisions into a stable class indication for the downstream fault-reporting logic. There is one result per accepted score set and no pipelining: a new set is accepted only after the previous result has been consumed.

## Interface
- `STABLE_COUNT`, default 4: consecutive identical confident decisions required before `stable_class` updates. Legal range 1..15.
- `MARGIN`, default 10'd16: minimum best-minus-second score difference for a confident decision. Unsigned; used only when the margin feature is compiled in.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: the score set on `scores` is valid.
- `in_ready` output, 1 bit: the block can accept a score set.
- `scores` input, 27 bits: score k, two's complement, occupies bits [9k+8:9k] for k = 0..2.
- `out_valid` output, 1 bit: a decision is presented.
- `out_ready` input, 1 bit: the consumer accepts the decision.
- `out_class` output, 2 bits: winning class 0..2, or 2'b11 when the result is unknown or low-confidence.
- `out_margin` output, 10 bits: unsigned difference between the best and second-best scores.
- `stable_valid` output, 1 bit: `stable_class` holds a debounced class.
- `stable_class` output, 2 bits: most recent debounced class.

## Operation
- FSM states: IDLE, SCAN, DECIDE, HOLD.
- **IDLE**
  - `in_ready` = 1.
  - When `in_valid` is high, the scores are latched and the FSM moves to SCAN with index k = 0.
- **SCAN** (exactly 3 cycles, k = 0, 1, 2)
  - k = 0: best = s0, best_idx = 0, second = -256.
  - k = 1, 2, signed compare:
    - If s_k > best: second takes the old best, best = s_k, best_idx = k.
    - Else if s_k > second: second = s_k.
  - Ties never replace, so the lowest index wins (e.g. 5, 5, 5 gives class 0 with margin 0).
- **DECIDE** (1 cycle)
  - margin = best - second, computed at 10 bits and zero-extended; range 0..511.
  - A decision is confident when margin >= `MARGIN` (feature enabled) or always (feature disabled).
  - Confident decision:
    - If best_idx equals `last_idx` and the run counter is non-zero, the counter increments, saturating at `STABLE_COUNT`.
    - Otherwise the counter is set to 1 and `last_idx` = best_idx.
    - When the counter equals `STABLE_COUNT`: `stable_class` = best_idx and `stable_valid` = 1.
  - Non-confident decision: class is reported as 2'b11 and the run counter clears to 0. `stable_class` and `stable_valid` are unchanged.
- **HOLD**
  - `out_valid` = 1; `out_class` and `out_margin` are held stable.
  - When `out_ready` is high, the FSM returns to IDLE.
- `in_valid` is ignored outside IDLE, where `in_ready` = 0.

## Timing
- Reset values: `in_ready` = 1 after reset release (IDLE). `out_valid` = 0, `out_class` = 2'b11, `out_margin` = 0, `stable_valid` = 0, `stable_class` = 0. Run counter = 0, `last_idx` = 0.
- Acceptance happens on edge N (`in_valid` and `in_ready` both high). SCAN occupies edges N+1..N+3, DECIDE is edge N+4, and `out_valid` is high from edge N+4 onward. Latency is 4 cycles.
- `stable_*` update on the same edge that raises `out_valid`.
- Handshake completion:
  - The decision is consumed on the edge where `out_valid` and `out_ready` are both high; `out_valid` falls on that edge.
  - `in_ready` rises on that same edge, so the next acceptance is no earlier than the following edge.
  - Minimum spacing is 6 cycles per score set with `out_ready` tied high.
- `out_ready` held low: HOLD persists indefinitely and outputs do not change.
- `rst` mid-operation (any state): everything returns immediately to reset values, the latched scores are discarded, and no `out_valid` is produced.

## Configuration
- `DECIDER_MARGIN_EN` defined:
  - The margin comparison against `MARGIN` is compiled in.
  - Low-margin results report 2'b11 and break the debounce run.
- `DECIDER_MARGIN_EN` undefined:
  - No comparator is built and every decision is confident.
  - `out_class` is always 0..2 after the first decision.
  - `out_margin` is still computed and output.

## Test plan
- **Reset:** assert `rst` mid-SCAN → all outputs at reset values, `in_ready` = 1 after release, no `out_valid` pulse.
- **Basic argmax:** scores (-20, 100, 37), `out_ready` = 1 → `out_class` = 1, `out_margin` = 63, `out_valid` high exactly 4 cycles after acceptance, for one cycle.
- **Extremes and ties:** scores (-256, 255, 255) → class 1, margin 0. Scores (-256, -256, 255) → class 2, margin 511.
- **Margin:** with `DECIDER_MARGIN_EN` and `MARGIN` = 16, scores (40, 30, 0) → `out_class` = 2'b11 and the run counter is cleared. Without the macro → `out_class` = 0, `out_margin` = 10.
- **Debounce** (`STABLE_COUNT` = 4): three confident class-2 decisions leave `stable_valid` = 0. The fourth sets `stable_class` = 2 and `stable_valid` = 1. A following class-0 decision leaves `stable_class` = 2, with the run counter at 1.
- **Backpressure:** hold `out_ready` = 0 for 20 cycles → outputs frozen, `in_ready` = 0, and `in_valid` pulses are ignored. Release → consumed, `in_ready` = 1 on the next cycle.

Source files
------------

// File: rtl/nn_class_decider.sv
// Argmax over three signed 9-bit class scores, with a debounced stable-class output.
// The `DECIDER_MARGIN_EN macro compiles in the best-minus-second confidence check against MARGIN.
module nn_class_decider #(
  parameter int unsigned STABLE_COUNT = 4,
  parameter logic [9:0]  MARGIN       = 10'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] scores,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_class,
  output logic [9:0]  out_margin,
  output logic        stable_valid,
  output logic [1:0]  stable_class
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, HOLD} state_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);

  state_t             state;
  logic [26:0]        sc_q;
  logic [1:0]         k;
  logic signed [8:0]  best;
  logic signed [8:0]  second;
  logic [1:0]         best_idx;
  logic [3:0]         cnt;
  logic [1:0]         last_idx;

  logic signed [8:0]  s_k;
  logic [9:0]         diff;
  logic               conf;
  logic [3:0]         cnt_nxt;

  always_comb begin
    s_k = '0;
    case (k)
      2'd0:    s_k = sc_q[8:0];
      2'd1:    s_k = sc_q[17:9];
      default: s_k = sc_q[26:18];
    endcase
  end

  // Both operands are sign-extended to 10 bits; best >= second, so the result is never negative.
  assign diff = {best[8], best} - {second[8], second};

`ifdef DECIDER_MARGIN_EN
  assign conf = (diff >= MARGIN);
`else
  logic unused_margin;
  assign unused_margin = ^MARGIN;
  assign conf = 1'b1;
`endif

  always_comb begin
    cnt_nxt = 4'd1;
    if ((best_idx == last_idx) && (cnt != '0))
      cnt_nxt = (cnt == STABLE_MAX) ? cnt : cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_class    <= 2'b11;
      out_margin   <= '0;
      stable_valid <= 1'b0;
      stable_class <= '0;
      sc_q         <= '0;
      k            <= '0;
      best         <= '0;
      second       <= '0;
      best_idx     <= '0;
      cnt          <= '0;
      last_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sc_q     <= scores;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (k == 2'd0) begin
            best     <= s_k;
            best_idx <= 2'd0;
            second   <= 9'h100;
          end else if (s_k > best) begin
            second   <= best;
            best     <= s_k;
            best_idx <= k;
          end else if (s_k > second) begin
            second   <= s_k;
          end
          if (k == 2'd2) state <= DECIDE;
          else           k     <= k + 2'd1;
        end
        DECIDE: begin
          out_margin <= diff;
          out_valid  <= 1'b1;
          state      <= HOLD;
          if (conf) begin
            out_class <= best_idx;
            cnt       <= cnt_nxt;
            last_idx  <= best_idx;
            if (cnt_nxt == STABLE_MAX) begin
              stable_class <= best_idx;
              stable_valid <= 1'b1;
            end
          end else begin
            out_class <= 2'b11;
            cnt       <= '0;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_class_decider.sv
// Directed bench for nn_class_decider: an independent argmax/debounce model feeds a scoreboard queue.
module tb_nn_class_decider;

  localparam int MARGIN_V = 16;
  localparam int STABLE_V = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] scores;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic [9:0]  out_margin;
  logic        stable_valid;
  logic [1:0]  stable_class;

  always #5 clk = ~clk;

  nn_class_decider #(.STABLE_COUNT(STABLE_V), .MARGIN(10'(MARGIN_V))) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .scores(scores),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_margin(out_margin), .stable_valid(stable_valid), .stable_class(stable_class)
  );

  typedef struct {
    logic [1:0] cls;
    logic [9:0] mar;
    logic       sv;
    logic [1:0] sc;
  } exp_t;

  exp_t       sb[$];
  int         n_asserts = 0;
  int         n_fail = 0;
  int         m_cnt = 0;
  int         m_last = 0;
  logic       m_sv = 1'b0;
  logic [1:0] m_sc = 2'd0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_push(input logic signed [8:0] a, input logic signed [8:0] b,
                            input logic signed [8:0] c);
    int   v[3];
    int   bi;
    int   sec;
    int   mar;
    bit   cf;
    exp_t e;
    v = '{int'(a), int'(b), int'(c)};
    bi = 0;
    for (int i = 1; i < 3; i++) if (v[i] > v[bi]) bi = i;
    sec = -100000;
    for (int j = 0; j < 3; j++) if (j != bi && v[j] > sec) sec = v[j];
    mar = v[bi] - sec;
`ifdef DECIDER_MARGIN_EN
    cf = (mar >= MARGIN_V);
`else
    cf = 1'b1;
`endif
    if (cf) begin
      if (bi == m_last && m_cnt != 0) begin
        if (m_cnt < STABLE_V) m_cnt++;
      end else begin
        m_cnt = 1;
        m_last = bi;
      end
      if (m_cnt == STABLE_V) begin
        m_sv = 1'b1;
        m_sc = 2'(bi);
      end
      e.cls = 2'(bi);
    end else begin
      m_cnt = 0;
      e.cls = 2'b11;
    end
    e.mar = 10'(mar);
    e.sv  = m_sv;
    e.sc  = m_sc;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_wait", 16'(in_ready), 16'd1);
  endtask

  task automatic send(input logic signed [8:0] a, input logic signed [8:0] b,
                      input logic signed [8:0] c);
    wait_ready();
    scores   = {c, b, a};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(a, b, c);
  endtask

  task automatic collect(output exp_t e);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", 16'(cyc), 16'd4);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 16'd0, 16'd1);
      e = '{cls: 2'b00, mar: 10'd0, sv: 1'b0, sc: 2'b00};
    end else begin
      e = sb.pop_front();
    end
    check("out_class", 16'(out_class), 16'(e.cls));
    check("out_margin", 16'(out_margin), 16'(e.mar));
    check("stable_valid", 16'(stable_valid), 16'(e.sv));
    check("stable_class", 16'(stable_class), 16'(e.sc));
    if (out_ready) begin
      @(posedge clk); #1;
      check("out_valid_one_cycle", 16'(out_valid), 16'd0);
      check("in_ready_after_consume", 16'(in_ready), 16'd1);
    end
  endtask

  task automatic run(input logic signed [8:0] a, input logic signed [8:0] b,
                     input logic signed [8:0] c);
    exp_t e;
    send(a, b, c);
    collect(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; scores = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_class", 16'(out_class), 16'd3);
    check("rst_out_margin", 16'(out_margin), 16'd0);
    check("rst_stable_valid", 16'(stable_valid), 16'd0);
    check("rst_stable_class", 16'(stable_class), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset while scanning discards the set.
    wait_ready();
    scores = {9'sd3, 9'sd2, 9'sd1};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 16'(in_ready), 16'd1);
    check("midrst_out_valid", 16'(out_valid), 16'd0);
    check("midrst_out_class", 16'(out_class), 16'd3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready_release", 16'(in_ready), 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("midrst_no_out_valid", 16'(seen), 16'd0);

    run(-9'sd20, 9'sd100, 9'sd37);
    run(-9'sd256, 9'sd255, 9'sd255);
    run(-9'sd256, -9'sd256, 9'sd255);
    run(9'sd5, 9'sd5, 9'sd5);
    run(9'sd40, 9'sd30, 9'sd0);

    // Debounce: four confident class-2 results in a row.
    for (int i = 0; i < 3; i++) run(9'sd0, -9'sd50, 9'sd100);
    check("debounce_3_not_stable", 16'(stable_valid), 16'd0);
    run(9'sd0, -9'sd50, 9'sd100);
    check("debounce_4_valid", 16'(stable_valid), 16'd1);
    check("debounce_4_class", 16'(stable_class), 16'd2);
    run(9'sd100, 9'sd0, -9'sd3);
    check("debounce_switch_hold", 16'(stable_class), 16'd2);
    for (int i = 0; i < 3; i++) run(9'sd120, -9'sd10, 9'sd20);
    check("debounce_switch_done", 16'(stable_class), 16'd0);

    // Backpressure: HOLD must freeze and ignore new input.
    out_ready = 1'b0;
    send(9'sd10, -9'sd5, 9'sd3);
    collect(e);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      scores = 27'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_out_class", 16'(out_class), 16'(e.cls));
      check("bp_out_margin", 16'(out_margin), 16'(e.mar));
      check("bp_in_ready", 16'(in_ready), 16'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 16'(out_valid), 16'd0);
    check("bp_release_in_ready", 16'(in_ready), 16'd1);

    run(-9'sd100, 9'sd7, -9'sd1);
    check("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
